// File: rtl/sa_autosa_sdp_autosahls_prelu_pipe.sv
// Two-stage PReLU/scale pipeline: per-lane product or passthrough, rounded arithmetic right shift, narrowing.
// Build option AUTOSA_PRELU_SAT_EN: saturating narrowing plus sat_cnt; otherwise results wrap to OUT_WIDTH.
module sa_autosa_sdp_autosahls_prelu_pipe #(
  parameter int IN_WIDTH    = 32,
  parameter int OP_WIDTH    = 32,
  parameter int OUT_WIDTH   = 32,
  parameter int CH          = 4,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic                      autosa_core_clk,
  input  logic                      autosa_core_rst,
  input  logic                      cfg_prelu_en,
  input  logic [SHIFT_WIDTH-1:0]    cfg_shift,
  input  logic                      in_pvld,
  output logic                      in_prdy,
  input  logic [CH*IN_WIDTH-1:0]    in_data,
  input  logic [CH*OP_WIDTH-1:0]    in_op,
  output logic                      out_pvld,
  input  logic                      out_prdy,
  output logic [CH*OUT_WIDTH-1:0]   out_data
`ifdef AUTOSA_PRELU_SAT_EN
  ,
  output logic [31:0]               sat_cnt
`endif
);

  localparam int PW = IN_WIDTH + OP_WIDTH;
  // One guard bit so the rounding bias can never wrap the sum.
  localparam int EW = PW + 1;

`ifdef AUTOSA_PRELU_SAT_EN
  localparam logic signed [EW-1:0] OUT_MAX = (EW'(1) <<< (OUT_WIDTH - 1)) - EW'(1);
  localparam logic signed [EW-1:0] OUT_MIN = ~OUT_MAX;
`endif

  logic                   s1_vld;
  logic signed [PW-1:0]   s1_val [CH];
  logic [CH-1:0]          s1_pass;
  logic [SHIFT_WIDTH-1:0] s1_shift;
  logic signed [PW-1:0]   s1_nxt [CH];
  logic [CH-1:0]          pass_nxt;
  logic [CH*OUT_WIDTH-1:0] s2_nxt;
  logic                   s1_rdy;
  logic                   s2_rdy;

  assign s2_rdy  = !out_pvld || out_prdy;
  assign s1_rdy  = !s1_vld || s2_rdy;
  assign in_prdy = s1_rdy;

  function automatic logic signed [EW-1:0] round_shift(input logic signed [PW-1:0] v,
                                                        input logic pass,
                                                        input logic [SHIFT_WIDTH-1:0] sh);
    int unsigned se;
    logic signed [EW-1:0] r;
    logic signed [EW-1:0] bias;
    se = 32'(sh);
    // Any shift of PW or more rounds to zero exactly as a shift of PW does.
    if (se > PW) se = PW;
    if (pass) se = 0;
    r = {v[PW-1], v};
    if (se != 0) begin
      bias = EW'(1) << (se - 1);
      r = (r + bias) >>> se;
    end
    return r;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] narrow(input logic signed [EW-1:0] r);
`ifdef AUTOSA_PRELU_SAT_EN
    if (r > OUT_MAX) return OUT_MAX[OUT_WIDTH-1:0];
    if (r < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
`endif
    return r[OUT_WIDTH-1:0];
  endfunction

`ifdef AUTOSA_PRELU_SAT_EN
  function automatic logic is_sat(input logic signed [EW-1:0] r);
    return (r > OUT_MAX) || (r < OUT_MIN);
  endfunction

  logic [CH-1:0] lane_sat;
  logic [32:0]   sat_sum;
  assign sat_sum = {1'b0, sat_cnt} + 33'($countones(lane_sat));
`endif

  always_comb begin
    pass_nxt = '0;
    s1_nxt   = '{default: '0};
    for (int k = 0; k < CH; k++) begin
      pass_nxt[k] = cfg_prelu_en && !in_data[k*IN_WIDTH + IN_WIDTH - 1];
      if (pass_nxt[k])
        s1_nxt[k] = PW'($signed(in_data[k*IN_WIDTH +: IN_WIDTH]));
      else
        s1_nxt[k] = PW'($signed(in_data[k*IN_WIDTH +: IN_WIDTH])) *
                    PW'($signed(in_op[k*OP_WIDTH +: OP_WIDTH]));
    end
  end

  always_comb begin
    s2_nxt = '0;
`ifdef AUTOSA_PRELU_SAT_EN
    lane_sat = '0;
`endif
    for (int k = 0; k < CH; k++) begin
      s2_nxt[k*OUT_WIDTH +: OUT_WIDTH] = narrow(round_shift(s1_val[k], s1_pass[k], s1_shift));
`ifdef AUTOSA_PRELU_SAT_EN
      lane_sat[k] = is_sat(round_shift(s1_val[k], s1_pass[k], s1_shift));
`endif
    end
  end

  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      s1_vld   <= 1'b0;
      s1_val   <= '{default: '0};
      s1_pass  <= '0;
      s1_shift <= '0;
      out_pvld <= 1'b0;
      out_data <= '0;
`ifdef AUTOSA_PRELU_SAT_EN
      sat_cnt  <= '0;
`endif
    end else begin
      if (s1_rdy) s1_vld <= in_pvld;
      // Config is captured alongside the beat so later changes never reach it.
      if (in_pvld && s1_rdy) begin
        s1_val   <= s1_nxt;
        s1_pass  <= pass_nxt;
        s1_shift <= cfg_shift;
      end
      if (s2_rdy) out_pvld <= s1_vld;
      if (s2_rdy && s1_vld) begin
        out_data <= s2_nxt;
`ifdef AUTOSA_PRELU_SAT_EN
        sat_cnt  <= sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_sa_autosa_sdp_autosahls_prelu_pipe.sv
// Self-checking bench for the PReLU pipe: directed cases plus random traffic against a behavioural model.
// Honours AUTOSA_PRELU_SAT_EN to match the DUT build (saturating vs wrapping narrowing).
module tb_sa_autosa_sdp_autosahls_prelu_pipe;
  localparam int CH = 4, IW = 32, OPW = 32, OUTW = 16, SW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prelu_en = 1'b0;
  logic [SW-1:0] shift = '0;
  logic in_pvld = 1'b0;
  logic in_prdy;
  logic [CH*IW-1:0] data = '0;
  logic [CH*OPW-1:0] op = '0;
  logic out_pvld;
  logic out_prdy = 1'b0;
  logic [CH*OUTW-1:0] out_data;
`ifdef AUTOSA_PRELU_SAT_EN
  logic [31:0] sat_cnt;
`endif

  always #5 clk = ~clk;

  sa_autosa_sdp_autosahls_prelu_pipe #(
    .IN_WIDTH(IW), .OP_WIDTH(OPW), .OUT_WIDTH(OUTW), .CH(CH), .SHIFT_WIDTH(SW)
  ) dut (
    .autosa_core_clk(clk),
    .autosa_core_rst(rst),
    .cfg_prelu_en(prelu_en),
    .cfg_shift(shift),
    .in_pvld(in_pvld),
    .in_prdy(in_prdy),
    .in_data(data),
    .in_op(op),
    .out_pvld(out_pvld),
    .out_prdy(out_prdy),
    .out_data(out_data)
`ifdef AUTOSA_PRELU_SAT_EN
    ,
    .sat_cnt(sat_cnt)
`endif
  );

  typedef struct {
    logic [63:0] val;
    int acc_cyc;
  } beat_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_lat = -1;
  bit lat_chk = 0;
  bit acc_fire = 0;
  bit stall_prev = 0;
  logic [63:0] prev_data = '0;
  logic [31:0] exp_sat = '0;
  beat_t sb[$];
  logic [63:0] out_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [127:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {a3, a2, a1, a0};
  endfunction

  // Reference: exact integer arithmetic, round-half-up as floor((x + 2^(s-1)) / 2^s).
  function automatic logic [63:0] model(input logic [127:0] d_bus, input logic [127:0] o_bus,
                                        input logic en, input logic [SW-1:0] sh, output int nsat);
    logic signed [127:0] d, o, x, dv, q;
    logic [63:0] res;
    res = '0;
    nsat = 0;
    for (int k = 0; k < CH; k++) begin
      d = $signed(d_bus[k*IW +: IW]);
      o = $signed(o_bus[k*OPW +: OPW]);
      if (en && d >= 0) q = d;
      else if (sh == 0) q = d * o;
      else begin
        dv = 128'sd1 <<< sh;
        x = d * o + dv / 2;
        q = x / dv;
        if (x < 0 && q * dv != x) q = q - 1;
      end
`ifdef AUTOSA_PRELU_SAT_EN
      if (q > 32767) begin q = 32767; nsat++; end
      else if (q < -32768) begin q = -32768; nsat++; end
`endif
      res[k*OUTW +: OUTW] = q[OUTW-1:0];
    end
    return res;
  endfunction

  task automatic step();
    beat_t b;
    int ns;
    @(negedge clk);
    acc_fire = 0;
    if (stall_prev) begin
      check("stall_data_stable", out_data, prev_data);
      check("stall_pvld_held", 64'(out_pvld), 64'd1);
    end
    check("in_prdy", 64'(in_prdy), 64'((sb.size() < 2) || out_prdy));
    if (out_pvld && out_prdy) begin
      check("no_extra_beat", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        b = sb.pop_front();
        check("out_data", out_data, b.val);
        last_lat = cyc - b.acc_cyc;
        if (lat_chk) check("latency", 64'(last_lat), 64'd2);
      end
      out_log.push_back(out_data);
    end
    if (in_pvld && in_prdy) begin
      b.val = model(data, op, prelu_en, shift, ns);
      b.acc_cyc = cyc;
      sb.push_back(b);
      exp_sat = exp_sat + 32'(ns);
      acc_fire = 1;
    end
    stall_prev = out_pvld && !out_prdy;
    prev_data = out_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_beat();
    logic [31:0] dv, ov;
    for (int k = 0; k < CH; k++) begin
      dv = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 2000)) - 32'd1000;
      ov = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 200)) - 32'd100;
      data[k*IW +: IW] = dv;
      op[k*OPW +: OPW] = ov;
    end
    prelu_en = 1'($urandom_range(0, 1));
    shift = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 63)) : SW'($urandom_range(0, 6));
  endtask

  task automatic drain(input bit toggle);
    in_pvld = 0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      out_prdy = toggle ? 1'(i % 2 == 0) : 1'b1;
      step();
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
`ifdef AUTOSA_PRELU_SAT_EN
    check("sat_cnt_total", 64'(sat_cnt), 64'(exp_sat));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, n_before;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_pvld", 64'(out_pvld), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
`ifdef AUTOSA_PRELU_SAT_EN
    check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
`endif
    rst = 0;
    check("rel_in_prdy", 64'(in_prdy), 64'd1);

    // PReLU mode, no shift, latency 2
    out_prdy = 1; prelu_en = 1; shift = 0;
    data = pk(5, -3, 0, -1); op = pk(2, 4, 7, -8);
    in_pvld = 1; lat_chk = 1;
    step();
    in_pvld = 0; data = '0; op = '0;
    repeat (3) step();
    check("r029_data", out_log[$], 64'h0008_0000_FFF4_0005);
    check("r029_lat", 64'(last_lat), 64'd2);

    // Rounded shift of products
    prelu_en = 0; shift = 2;
    data = pk(6, -6, 0, 0); op = pk(3, 3, 0, 0);
    in_pvld = 1;
    step();
    in_pvld = 0;
    repeat (3) step();
    check("r030_data", out_log[$], 64'h0000_0000_FFFC_0005);

    // Narrowing overflow on lane 0
    shift = 0;
    data = pk(32'h7FFF_FFFF, 0, 0, 0); op = pk(2, 0, 0, 0);
    in_pvld = 1;
    step();
    in_pvld = 0;
    repeat (3) step();
`ifdef AUTOSA_PRELU_SAT_EN
    check("r032_sat_lane", out_log[$], 64'h0000_0000_0000_7FFF);
    check("r032_sat_cnt", 64'(sat_cnt), 64'd1);
`else
    check("r032_wrap_lane", out_log[$], 64'h0000_0000_0000_FFFE);
`endif
    lat_chk = 0;

    // Shift changes between consecutive accepted beats
    shift = 0; data = pk(256, 0, 0, 0); op = pk(1, 0, 0, 0);
    in_pvld = 1;
    step();
    check("r034_second_accept", 64'(in_prdy), 64'd1);
    shift = 4;
    step();
    in_pvld = 0; shift = 0;
    repeat (3) step();
    check("r034_first", out_log[out_log.size()-2], 64'h0000_0000_0000_0100);
    check("r034_second", out_log[$], 64'h0000_0000_0000_0010);

    // 8-beat burst with out_prdy toggling
    n_acc = 0;
    n_before = out_log.size();
    rand_beat();
    for (int i = 0; i < 100 && n_acc < 8; i++) begin
      out_prdy = 1'(i % 2 == 0);
      in_pvld = 1;
      step();
      if (acc_fire) begin
        n_acc++;
        rand_beat();
      end
    end
    check("r031_accepted", 64'(n_acc), 64'd8);
    drain(1);
    check("r031_emitted", 64'(out_log.size() - n_before), 64'd8);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_beat();
      in_pvld = 1'($urandom_range(0, 1));
      out_prdy = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(0);

    // Reset with both stages occupied
    out_prdy = 0;
    rand_beat(); in_pvld = 1;
    step();
    rand_beat();
    step();
    check("r033_full_prdy", 64'(in_prdy), 64'd0);
    check("r033_full_pvld", 64'(out_pvld), 64'd1);
    rst = 1; in_pvld = 1; out_prdy = 1;
    @(posedge clk);
    #1;
    check("r033_out_pvld", 64'(out_pvld), 64'd0);
    check("r033_in_prdy", 64'(in_prdy), 64'd1);
`ifdef AUTOSA_PRELU_SAT_EN
    check("r033_sat_cnt", 64'(sat_cnt), 64'd0);
`endif
    rst = 0; in_pvld = 0;
    sb.delete();
    exp_sat = '0;
    stall_prev = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("r033_no_stale", 64'(out_pvld), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
